// File: rtl/divisor_seq_nbits.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, WIDTH-cycle RUN.
// Define DIVISOR_SIGNED_EN for two's-complement operands (truncating division); default is unsigned.
module divisor_seq_nbits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             ERR
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    // r_dvd doubles as the quotient register: dividend bits shift out the top, quotient bits in at the bottom
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_borrow  = w_diff[WIDTH];
    assign w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], ~w_borrow};

`ifdef DIVISOR_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag = A[WIDTH-1] ? ('0 - A) : A;
    assign w_b_mag = B[WIDTH-1] ? ('0 - B) : B;
    assign w_q_fin = r_neg_q ? ('0 - w_quo_nxt) : w_quo_nxt;
    assign w_r_fin = r_neg_r ? ('0 - w_rem_nxt) : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start && (r_state == IDLE || r_state == DONE)) begin
            r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r <= A[WIDTH-1];
        end
    end
`else
    assign w_a_mag = A;
    assign w_b_mag = B;
    assign w_q_fin = w_quo_nxt;
    assign w_r_fin = w_rem_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            Q       <= '0;
            R       <= '0;
            ERR     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        if (B == '0) begin
                            r_state <= DONE;
                            Q       <= '1;
                            R       <= A;
                            ERR     <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_rem   <= '0;
                            r_cnt   <= CW'(WIDTH);
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                        Q       <= w_q_fin;
                        R       <= w_r_fin;
                        ERR     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_divisor_seq_nbits.sv
// Table-driven bench for divisor_seq_nbits (WIDTH=8) with a result scoreboard checked on each done pulse.
module tb_divisor_seq_nbits;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         ERR;

    divisor_seq_nbits #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .ERR   (ERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } res_t;

    vec_t tbl[$];
    res_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        res_t ex;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done: got done=1, expected done=0 (no pending request)");
            end else begin
                ex = sb.pop_front();
                chk("result_Q", 32'(Q), 32'(ex.q));
                chk("result_R", 32'(R), 32'(ex.r));
                chk("result_ERR", 32'(ERR), 32'(ex.e));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
        res_t x;
        x.q = q;
        x.r = r;
        x.e = e;
        sb.push_back(x);
    endtask

    // Called just after the accepting edge; cyc=1 means done is already visible
    task automatic wait_done(output int unsigned cyc, output int unsigned bcyc);
        cyc  = 1;
        bcyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic e, input string tag);
        int unsigned cyc;
        int unsigned bcyc;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        push_exp(q, r, e);
        @(negedge clk);
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        wait_done(cyc, bcyc);
        chk({tag, "_latency"}, 32'(cyc), e ? 32'd1 : 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(bcyc), e ? 32'd0 : 32'(W));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_Q_hold"}, 32'(Q), 32'(q));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

    initial begin : main
        int unsigned cyc;
        int unsigned bcyc;
        int          nd0;

`ifdef DIVISOR_SIGNED_EN
        tbl.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});
        tbl.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
        tbl.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0});
        tbl.push_back('{8'hF9, 8'hF9, 8'h01, 8'h00, 1'b0});
        tbl.push_back('{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0});
        tbl.push_back('{8'h0D, 8'h00, 8'hFF, 8'h0D, 1'b1});
        tbl.push_back('{8'hF0, 8'h00, 8'hFF, 8'hF0, 1'b1});
`else
        tbl.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0});
        tbl.push_back('{8'd13,  8'd0,   8'd255, 8'd13, 1'b1});
        tbl.push_back('{8'd0,   8'd5,   8'd0,   8'd0,  1'b0});
        tbl.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0});
        tbl.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0});
        tbl.push_back('{8'd7,   8'd9,   8'd0,   8'd7,  1'b0});
        tbl.push_back('{8'd254, 8'd16,  8'd15,  8'd14, 1'b0});
        tbl.push_back('{8'd1,   8'd255, 8'd0,   8'd1,  1'b0});
        tbl.push_back('{8'd128, 8'd3,   8'd42,  8'd2,  1'b0});
        tbl.push_back('{8'd0,   8'd0,   8'd255, 8'd0,  1'b1});
`endif

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_Q", 32'(Q), 32'd0);
        chk("reset_R", 32'(R), 32'd0);
        chk("reset_ERR", 32'(ERR), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++)
            run_one(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].e, $sformatf("vec%0d", i));

        // Back-to-back: second start issued during the DONE cycle of the first
        @(negedge clk);
        start = 1'b1;
        A     = 8'd3;
        B     = 8'd9;
        push_exp(8'd0, 8'd3, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcyc);
        chk("b2b_first_latency", 32'(cyc), 32'(W + 1));
        start = 1'b1;
        A     = 8'd9;
        B     = 8'd9;
        push_exp(8'd1, 8'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        wait_done(cyc, bcyc);
        chk("b2b_second_latency", 32'(cyc), 32'(W + 1));
        repeat (2) @(negedge clk);

        // start held high throughout RUN must be neither accepted nor queued
        start = 1'b1;
        A     = 8'd100;
        B     = 8'd10;
        push_exp(8'd10, 8'd0, 1'b0);
        @(negedge clk);
        nd0 = n_done;
        A   = 8'd50;
        B   = 8'd5;
        repeat (W - 1) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_start_done_count", 32'(n_done - nd0), 32'd1);
        chk("held_start_idle_busy", 32'(busy), 32'd0);

        // Reset on the third RUN cycle aborts with no done pulse
        start = 1'b1;
        A     = 8'd255;
        B     = 8'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        nd0 = n_done;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_Q", 32'(Q), 32'd0);
        chk("abort_R", 32'(R), 32'd0);
        chk("abort_ERR", 32'(ERR), 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(n_done - nd0), 32'd0);

        // Reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        A     = 8'd20;
        B     = 8'd3;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_vs_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_vs_start_busy_after", 32'(busy), 32'd0);
        chk("rst_vs_start_done_after", 32'(done), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/divisor_seq_nbits.md
DIVISOR_SEQ_NBITS -- requirements
Module: divisor_seq_nbits

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand, quotient and remainder width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only when accepted per REQ-010.
REQ-005 A  input  WIDTH  dividend, sampled on the accepting edge.
REQ-006 B  input  WIDTH  divisor, sampled on the accepting edge.
REQ-007 busy  output  1  high while iterations are in progress.
REQ-008 done  output  1  one-cycle pulse; Q, R and ERR are valid from this cycle on.
REQ-009 Q, R, ERR  output  WIDTH, WIDTH, 1  quotient, remainder, divide-by-zero flag; all registered.

Function
REQ-010 FSM states: IDLE, RUN, DONE; start is accepted on an edge where state is IDLE or DONE and start=1; otherwise it is ignored.
REQ-011 On accept with B!=0: latch A and B, clear the partial remainder, load the iteration counter with WIDTH, go to RUN.
REQ-012 RUN: one restoring step per cycle, MSB first. Shift {rem, next dividend bit}. Trial-subtract B at WIDTH+1 bits. No borrow: keep the difference and set the quotient bit to 1. Borrow: restore and set the quotient bit to 0.
REQ-013 RUN lasts exactly WIDTH cycles; the edge completing the last step enters DONE and updates Q, R and ERR=0.
REQ-014 Latency: start accepted at edge k gives busy=1 from edge k to edge k+WIDTH, and done=1 from edge k+WIDTH to edge k+WIDTH+1.
REQ-015 Divide by zero (B==0 on accept): skip RUN and enter DONE at the accepting edge+1. Set Q=all ones, R=A, ERR=1. busy stays 0.
REQ-016 busy=1 only in RUN; done=1 only in DONE; DONE returns to IDLE after one cycle unless start is accepted there.
REQ-017 Q, R and ERR hold their last values until the next DONE entry; A and B changes during RUN have no effect.
REQ-018 A<B gives Q=0, R=A; A==B gives Q=1, R=0; invariant on unsigned results: A == Q*B + R with R<B.
REQ-019 start=1 during RUN is ignored and is not queued.

Reset
REQ-020 rst=1 at any edge forces IDLE and sets busy=0, done=0, Q=0, R=0, ERR=0, and clears the internal remainder and counter.
REQ-021 rst during RUN aborts the operation; no done pulse is produced for the aborted operation.
REQ-022 rst has priority over a simultaneous start; the start is dropped.

Configuration
REQ-023 Macro DIVISOR_SIGNED_EN defined: A and B are two's complement. Magnitudes are divided per REQ-012. The quotient is negated when the operand signs differ, and the remainder takes the sign of A (truncation toward zero). Sign fix is applied on DONE entry with no latency change. Divide by zero follows REQ-015 unchanged. Most-negative/-1 gives Q=most-negative, R=0, ERR=0.
REQ-024 Macro DIVISOR_SIGNED_EN undefined: all operands and results are unsigned and no sign logic is synthesised.

Verification (WIDTH=8)
REQ-025 A=200, B=7, start one cycle -> busy for 8 cycles, then done pulse with Q=28, R=4, ERR=0.
REQ-026 A=13, B=0 -> done one cycle after accept with Q=255, R=13, ERR=1, busy never high.
REQ-027 A=3, B=9 then, in the DONE cycle, start with A=9, B=9 -> first result Q=0, R=3; second accepted back-to-back, result Q=1, R=0.
REQ-028 A=100, B=10 accepted, then start=1 with A=50, B=5 held through RUN -> single result Q=10, R=0; one done only.
REQ-029 rst=1 on the 3rd RUN cycle of A=255, B=2 -> next cycle busy=0, done=0, Q=R=0, ERR=0; no later done.
REQ-030 DIVISOR_SIGNED_EN: A=0xF9 (-7), B=0x02 -> Q=0xFD (-3), R=0xFF (-1); A=0x80, B=0xFF -> Q=0x80, R=0x00.
